// File: rtl/i2c_slave_regs_if.sv
// rtl/i2c_slave_regs_if.sv - I2C pin bundle between a bus master and the register responder
interface i2c_slave_regs_if;
  logic scl_i;
  logic sda_i;
  logic sda_o;
  logic sda_t;

  modport master (output scl_i, output sda_i, input sda_o, input sda_t);
  modport slave  (input scl_i, input sda_i, output sda_o, output sda_t);
endinterface

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C responder with a 32x8 register file, 13-bit LSB-first address frame
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_slave_regs_if.slave        bus,
  input  logic                   loc_we,
  input  logic [4:0]             loc_addr,
  input  logic [7:0]             loc_wdata,
  output logic [7:0]             loc_rdata,
  output logic                   wr_strobe,
  output logic [4:0]             wr_addr,
  output logic [7:0]             wr_data,
  output logic                   busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK1, DELAY, RD_DATA, RD_ACK, WR_DATA, WR_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d, scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [7:0]  regfile [32];
  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [12:0] sreg, sreg_nxt;
  logic [4:0]  mem_addr, mem_addr_nxt;
  logic [7:0]  rx, rx_nxt, tx, tx_nxt, rx_in;
  logic        sda_t_q, sda_t_nxt, busy_nxt, wr_strobe_nxt, bus_we, addr_match;
  logic [4:0]  wr_addr_nxt;
  logic [7:0]  wr_data_nxt;

  // Bring SCL/SDA into the clk domain, then keep one extra flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_det  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det   = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_in      = {sda_s, rx[7:1]};
  assign addr_match = (sreg[12:6] == SLAVE_ADDR);
  assign bus.sda_o  = 1'b0;
  assign bus.sda_t  = sda_t_q;

  // Protocol next-state: STOP and START override everything, then per-state bit handling
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sreg_nxt      = sreg;
    mem_addr_nxt  = mem_addr;
    rx_nxt        = rx;
    tx_nxt        = tx;
    sda_t_nxt     = sda_t_q;
    busy_nxt      = busy;
    wr_strobe_nxt = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    bus_we        = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      sda_t_nxt = 1'b1;
      busy_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = 4'd0;
      sda_t_nxt = 1'b1;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_t_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
        ADDR: if (scl_rise) begin
          // rw arrives first and ends up in bit 0, the device address in the top 7 bits
          sreg_nxt = {sda_s, sreg[12:1]};
          if (cnt == 4'd12) begin
            cnt_nxt   = 4'd0;
            state_nxt = ACK1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        ACK1: begin
          if (!addr_match) begin
            state_nxt = WAIT_STOP;
          end else begin
            busy_nxt     = 1'b1;
            mem_addr_nxt = sreg[5:1];
            if (scl_fall) begin
              if (cnt == 4'd0) begin
                sda_t_nxt = 1'b0;
                cnt_nxt   = 4'd1;
              end else begin
                sda_t_nxt = 1'b1;
                cnt_nxt   = 4'd0;
                if (sreg[0]) begin
                  state_nxt = WR_DATA;
                end else begin
                  // Snapshot so local writes during the read cannot corrupt the byte in flight
                  state_nxt = DELAY;
                  tx_nxt    = regfile[mem_addr];
                end
              end
            end
          end
        end
        DELAY: if (scl_fall) begin
          if (cnt == 4'd1) begin
            sda_t_nxt = tx[0];
            tx_nxt    = {1'b0, tx[7:1]};
            cnt_nxt   = 4'd0;
            state_nxt = RD_DATA;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (cnt == 4'd7) begin
            sda_t_nxt = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = RD_ACK;
          end else begin
            sda_t_nxt = tx[0];
            tx_nxt    = {1'b0, tx[7:1]};
            cnt_nxt   = cnt + 4'd1;
          end
        end
        RD_ACK: begin
          sda_t_nxt = 1'b1;
          if (scl_fall) state_nxt = WAIT_STOP;
        end
        WR_DATA: if (scl_rise) begin
          rx_nxt = rx_in;
          if (cnt == 4'd7) begin
            bus_we        = 1'b1;
            wr_strobe_nxt = 1'b1;
            wr_addr_nxt   = mem_addr;
            wr_data_nxt   = rx_in;
            cnt_nxt       = 4'd0;
            state_nxt     = WR_ACK;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (cnt == 4'd0) begin
            sda_t_nxt = 1'b0;
            cnt_nxt   = 4'd1;
          end else begin
            sda_t_nxt = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = WAIT_STOP;
          end
        end
        WAIT_STOP: sda_t_nxt = 1'b1;
        default: begin
          state_nxt = IDLE;
          sda_t_nxt = 1'b1;
        end
      endcase
    end
  end

  // Protocol state register; async reset releases SDA immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      sreg      <= 13'd0;
      mem_addr  <= 5'd0;
      rx        <= 8'd0;
      tx        <= 8'd0;
      sda_t_q   <= 1'b1;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sreg      <= sreg_nxt;
      mem_addr  <= mem_addr_nxt;
      rx        <= rx_nxt;
      tx        <= tx_nxt;
      sda_t_q   <= sda_t_nxt;
      busy      <= busy_nxt;
      wr_strobe <= wr_strobe_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
    end
  end

  // Register file; the bus write is applied last so it wins a same-index collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regfile[i] <= 8'h00;
    end else begin
      if (loc_we) regfile[loc_addr] <= loc_wdata;
      if (bus_we) regfile[mem_addr] <= rx_in;
    end
  end

  // Registered local read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) loc_rdata <= 8'h00;
    else      loc_rdata <= regfile[loc_addr];
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - scoreboard bench for i2c_slave_regs
module tb_i2c_slave_regs;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl, sda_m;
  logic       loc_we;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       wr_strobe, busy;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;
  wr_ev_t     wr_q[$];
  logic [7:0] rd_q[$];
  logic       watch = 1'b0;
  logic       saw_low = 1'b0;
  logic       saw_busy = 1'b0;

  i2c_slave_regs_if bus ();

  assign bus.scl_i = scl;
  assign bus.sda_i = sda_m & bus.sda_t;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop the expected bus write whenever the DUT reports one
  always @(negedge clk) begin
    if (rst && wr_strobe) begin
      if (wr_q.size() == 0) begin
        check("wr_strobe_unexpected", {31'd0, wr_strobe}, 32'd0);
      end else begin
        wr_ev_t ev;
        ev = wr_q.pop_front();
        check("wr_addr", {27'd0, wr_addr}, {27'd0, ev.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, ev.d});
      end
    end
    if (watch) begin
      if (!bus.sda_t) saw_low = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // One SCL period starting and ending with SCL low; coll overlaps a local write to index 2 with the rise
  task automatic bit_xfer(input logic b, input logic exp_t, input string tag, input bit coll);
    repeat (2) @(negedge clk);
    sda_m = b;
    repeat (6) @(negedge clk);
    scl = 1'b1;
    if (coll) begin
      loc_we    = 1'b1;
      loc_addr  = 5'd2;
      loc_wdata = 8'hEE;
    end
    repeat (3) @(negedge clk);
    loc_we = 1'b0;
    @(negedge clk);
    check(tag, {31'd0, bus.sda_t}, {31'd0, exp_t});
    repeat (4) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic start_cond();
    repeat (4) @(negedge clk);
    sda_m = 1'b0;
    repeat (4) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic rep_start();
    repeat (2) @(negedge clk);
    sda_m = 1'b1;
    repeat (6) @(negedge clk);
    scl = 1'b1;
    repeat (4) @(negedge clk);
    sda_m = 1'b0;
    repeat (4) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    repeat (2) @(negedge clk);
    sda_m = 1'b0;
    repeat (6) @(negedge clk);
    scl = 1'b1;
    repeat (4) @(negedge clk);
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_we = 1'b1;
    loc_addr = a;
    loc_wdata = d;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic loc_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    loc_addr = a;
    rd_q.push_back(exp);
    @(negedge clk);
    check(tag, {24'd0, loc_rdata}, {24'd0, rd_q.pop_front()});
  endtask

  task automatic write_body(input logic [6:0] a, input logic [4:0] m, input logic [7:0] d,
                            input bit ack, input bit coll);
    logic [12:0] w;
    wr_ev_t      ev;
    w = {a, m, 1'b1};
    for (int i = 0; i < 13; i++) bit_xfer(w[i], 1'b1, "wr_addr_bit", 1'b0);
    bit_xfer(1'b1, ~ack, "wr_ack1", 1'b0);
    check("wr_busy", {31'd0, busy}, {31'd0, ack});
    if (ack) begin
      ev.a = m;
      ev.d = d;
      wr_q.push_back(ev);
    end
    for (int i = 0; i < 8; i++) bit_xfer(d[i], 1'b1, "wr_data_bit", coll && (i == 7));
    bit_xfer(1'b1, ~ack, "wr_ack2", 1'b0);
    stop_cond();
    check("wr_busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [4:0] m, input logic [7:0] d,
                           input bit ack, input bit coll);
    start_cond();
    write_body(a, m, d, ack, coll);
  endtask

  task automatic bus_read(input logic [6:0] a, input logic [4:0] m, input logic [7:0] exp,
                          input bit clob);
    logic [12:0] w;
    w = {a, m, 1'b0};
    start_cond();
    for (int i = 0; i < 13; i++) bit_xfer(w[i], 1'b1, "rd_addr_bit", 1'b0);
    bit_xfer(1'b1, 1'b0, "rd_ack1", 1'b0);
    check("rd_busy", {31'd0, busy}, 32'd1);
    bit_xfer(1'b1, 1'b1, "rd_delay0", 1'b0);
    bit_xfer(1'b1, 1'b1, "rd_delay1", 1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, exp[i], $sformatf("rd_bit%0d", i), 1'b0);
      if (clob && i == 2) loc_write(m, ~exp);
    end
    bit_xfer(1'b1, 1'b1, "rd_nack_released", 1'b0);
    stop_cond();
  endtask

  initial begin
    logic [12:0] w;
    logic [7:0]  d;
    rst = 1'b0;
    scl = 1'b1;
    sda_m = 1'b1;
    loc_we = 1'b0;
    loc_addr = 5'd0;
    loc_wdata = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_sda_t", {31'd0, bus.sda_t}, 32'd1);
    check("rst_sda_o", {31'd0, bus.sda_o}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_loc_rdata", {24'd0, loc_rdata}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Basic bus write
    bus_write(7'h50, 5'd5, 8'hA5, 1'b1, 1'b0);
    loc_read(5'd5, 8'hA5, "rf5_after_write");

    // Local write then bus read, with a local overwrite while the byte is in flight
    loc_write(5'd9, 8'h3C);
    bus_read(7'h50, 5'd9, 8'h3C, 1'b1);
    loc_read(5'd9, 8'hC3, "rf9_after_local_overwrite");

    // Foreign address: no ack, no busy, no strobe, nothing written
    saw_low = 1'b0;
    saw_busy = 1'b0;
    watch = 1'b1;
    bus_write(7'h51, 5'd7, 8'h77, 1'b0, 1'b0);
    watch = 1'b0;
    check("mm_sda_pulled", {31'd0, saw_low}, 32'd0);
    check("mm_busy_seen", {31'd0, saw_busy}, 32'd0);
    loc_read(5'd7, 8'h00, "rf7_untouched");
    loc_read(5'd5, 8'hA5, "rf5_untouched");

    // Repeated START after 6 address bits
    w = {7'h50, 5'd4, 1'b1};
    start_cond();
    for (int i = 0; i < 6; i++) bit_xfer(w[i], 1'b1, "rs_addr_bit", 1'b0);
    rep_start();
    write_body(7'h50, 5'd0, 8'h11, 1'b1, 1'b0);
    loc_read(5'd0, 8'h11, "rf0_after_rep_start");
    loc_read(5'd4, 8'h00, "rf4_untouched");

    // Local and bus write to index 2 in the same clk
    bus_write(7'h50, 5'd2, 8'h22, 1'b1, 1'b1);
    loc_read(5'd2, 8'h22, "rf2_bus_wins");

    // Reset during data bit 4 of a write
    w = {7'h50, 5'd12, 1'b1};
    d = 8'h96;
    start_cond();
    for (int i = 0; i < 13; i++) bit_xfer(w[i], 1'b1, "ra_addr_bit", 1'b0);
    bit_xfer(1'b1, 1'b0, "ra_ack1", 1'b0);
    for (int i = 0; i < 4; i++) bit_xfer(d[i], 1'b1, "ra_data_bit", 1'b0);
    repeat (2) @(negedge clk);
    sda_m = d[4];
    repeat (6) @(negedge clk);
    scl = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_sda_t", {31'd0, bus.sda_t}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
    @(negedge clk);
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 32; i++) loc_read(5'(i), 8'h00, "rf_cleared");
    bus_write(7'h50, 5'd31, 8'h5A, 1'b1, 1'b0);
    loc_read(5'd31, 8'h5A, "rf31_after_reset");

    repeat (4) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
